lc3_mem_arbiter: RTL and testbench
==================================

// Module: lc3_mem_arbiter
// PURPOSE
//   Sequences and shares the single LC-3 memory port between two requesters: the CPU control FSM
//   (CS/WE/MAR/MDR, waits on READY) and a program loader/debug port (req/ack).
//   Generates READY for the CPU, inserts WAIT_STATES memory cycles per access,
//   and alternates grants on contention so neither side starves. Sits between FSM/MAR/MDR and SRAM.
// PARAMETERS
//   ADDR_W       16  address width
//   DATA_W       16  data width
//   WAIT_STATES  2   cycles mem_en held per access; legal range >=1
// PORTS
//   CLK        in   1       clock, rising edge
//   RESET      in   1       asynchronous, active-high reset
//   cpu_cs     in   1       CPU request; held until cpu_ready
//   cpu_we     in   1       CPU write (1) / read (0)
//   cpu_addr   in   ADDR_W  CPU address (MAR)
//   cpu_wdata  in   DATA_W  CPU write data (MDR)
//   cpu_rdata  out  DATA_W  last CPU read data
//   cpu_ready  out  1       READY to FSM, 1-cycle pulse at completion
//   ldr_req    in   1       loader request; held until ldr_ack
//   ldr_we     in   1       loader write/read
//   ldr_addr   in   ADDR_W  loader address
//   ldr_wdata  in   DATA_W  loader write data
//   ldr_rdata  out  DATA_W  last loader read data
//   ldr_ack    out  1       loader completion, 1-cycle pulse
//   mem_en     out  1       SRAM enable
//   mem_we     out  1       SRAM write enable
//   mem_addr   out  ADDR_W  SRAM address (registered)
//   mem_wdata  out  DATA_W  SRAM write data (registered)
//   mem_rdata  in   DATA_W  SRAM read data, valid at edge ending last ACCESS cycle
//   owner      out  1       0=CPU, 1=loader; valid while mem_en=1
// BEHAVIOUR
//   States: IDLE -> ACCESS -> RESP -> IDLE.
//   Reset (async): state=IDLE; all outputs 0; cnt=0; last_owner=LDR, so the CPU wins the first tie.
//   IDLE: sample cpu_cs/ldr_req.
//     - One requester: grant it.
//     - Both requesting: grant the one != last_owner.
//     - On grant, latch we/addr/wdata into mem_*, set owner, cnt=WAIT_STATES-1, go ACCESS.
//     - No request: stay IDLE, mem_en=0.
//   ACCESS: mem_en=1; mem_we=latched we for every ACCESS cycle.
//     - cnt decrements each cycle; at cnt==0 go RESP.
//     - On a read, capture mem_rdata into cpu_rdata or ldr_rdata (per owner) at that edge.
//   RESP: mem_en=0; pulse cpu_ready or ldr_ack (per owner) for exactly 1 cycle; last_owner<=owner; go IDLE.
//   Latency: request seen in IDLE cycle T -> ACCESS T+1..T+WAIT_STATES -> ready/ack in T+WAIT_STATES+1.
//   Minimum one IDLE cycle between accesses. The CPU FSM leaves its state on the READY edge,
//     so cpu_cs high in IDLE is always a new request.
//   Inputs change mid-access: addr/wdata/we ignored after grant (latched).
//   Request dropped mid-access: access still completes; pulse still issued; no abort.
//   Writes never modify cpu_rdata/ldr_rdata.
//   Reset mid-access: immediate IDLE, mem_en/mem_we=0, no pulse; the interrupted write is undefined in SRAM.
//   cnt width = $clog2(WAIT_STATES)+1.
// TESTING
//   1. CPU read 0x3000 (SRAM=0x1234), W=2, cs at T -> mem_en T+1..T+2, cpu_ready T+3 only, cpu_rdata=0x1234.
//   2. Loader write 0x3001<-0xBEEF -> mem_we 2 cycles, ldr_ack 1 pulse, SRAM[0x3001]=0xBEEF, cpu_rdata unchanged.
//   3. First tie after reset: CPU and loader both request at T -> CPU ready T+3, loader ack T+7;
//      a second tie grants the loader first.
//   4. CPU cs held across two FSM states (two reads 0x3000, 0x3002) -> two accesses, IDLE gap of 1 cycle, two ready pulses.
//   5. cpu_addr changed 0x3000->0x4000 during ACCESS -> mem_addr stays 0x3000.
//   6. RESET pulsed in 2nd ACCESS cycle -> mem_en, cpu_ready 0 same cycle; after release, fresh request is served normally.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// Shares the single LC-3 SRAM port between the CPU control FSM and the loader/debug port.
// Each access holds mem_en for WAIT_STATES cycles, then pulses cpu_ready or ldr_ack for one cycle.
//
//   state  | meaning
//   IDLE   | no access in flight; arbitrate cpu_cs / ldr_req
//   ACCESS | mem_en high, counting down the wait states
//   RESP   | one-cycle completion pulse to the owner

module lc3_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam int               CNT_W    = $clog2(WAIT_STATES) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES - 1);
    localparam logic             OWN_CPU  = 1'b0;
    localparam logic             OWN_LDR  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic             owner_q;
    logic             last_owner;
    logic             grant;
    logic             grant_ldr;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_ldr = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        ldr_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_cs || ldr_req) begin
                    grant = 1'b1;
                    // On a tie the side that was not served last wins.
                    if (cpu_cs && ldr_req) begin
                        grant_ldr = (last_owner == OWN_CPU);
                    end else begin
                        grant_ldr = ldr_req;
                    end
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = we_q;
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                cpu_ready = (owner_q == OWN_CPU);
                ldr_ack   = (owner_q == OWN_LDR);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            owner_q    <= OWN_CPU;
            last_owner <= OWN_LDR;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            if (grant) begin
                cnt     <= CNT_INIT;
                owner_q <= grant_ldr;
                if (grant_ldr) begin
                    we_q      <= ldr_we;
                    mem_addr  <= ldr_addr;
                    mem_wdata <= ldr_wdata;
                end else begin
                    we_q      <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
            end
            if (state == ACCESS) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else if (!we_q) begin
                    // SRAM data is valid at the edge that ends the last ACCESS cycle.
                    if (owner_q == OWN_LDR) begin
                        ldr_rdata <= mem_rdata;
                    end else begin
                        cpu_rdata <= mem_rdata;
                    end
                end
            end
            if (state == RESP) begin
                last_owner <= owner_q;
            end
        end
    end

    assign owner = owner_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter with a behavioural SRAM; completion pulses are
// checked by a monitor against a queue of expected (owner, cycle, read data) entries.

module tb_lc3_mem_arbiter;

    logic        CLK;
    logic        RESET;
    logic        cpu_cs, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        ldr_req, ldr_we;
    logic [15:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic        ldr_ack;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner;

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(2)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cpu_cs    (cpu_cs),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_rdata (ldr_rdata),
        .ldr_ack   (ldr_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    typedef struct {
        bit          is_ldr;
        int          cyc;
        logic [15:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          c;
    logic [15:0] sram [0:65535];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (cyc == 0) begin
            sram[16'h3000] <= 16'h1234;
            sram[16'h3002] <= 16'h5678;
            sram[16'h4000] <= 16'hAAAA;
        end else if (mem_en && mem_we) begin
            sram[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = sram[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: checks the SRAM-side outputs mid-cycle, returns just after the next edge.
    task automatic tick(input logic en, input logic we, input logic own, input logic [15:0] addr);
        @(negedge CLK);
        check("mem_en", {31'd0, mem_en}, {31'd0, en});
        if (en) begin
            check("mem_we", {31'd0, mem_we}, {31'd0, we});
            check("owner", {31'd0, owner}, {31'd0, own});
            check("mem_addr", {16'd0, mem_addr}, {16'd0, addr});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_pulse(input bit is_ldr, input int at_cyc, input logic [15:0] rdata);
        exp_t e;
        e.is_ldr = is_ldr;
        e.cyc    = at_cyc;
        e.rdata  = rdata;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (!RESET && (cpu_ready || ldr_ack)) begin
            if (exp_q.size() == 0) begin
                check("spurious_pulse", {30'd0, cpu_ready, ldr_ack}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_who", {30'd0, cpu_ready, ldr_ack}, mon_e.is_ldr ? 32'd1 : 32'd2);
                check("pulse_cycle", cyc, mon_e.cyc);
                check(mon_e.is_ldr ? "ldr_rdata" : "cpu_rdata",
                      {16'd0, (mon_e.is_ldr ? ldr_rdata : cpu_rdata)}, {16'd0, mon_e.rdata});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1;
        cpu_cs = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        #2;
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_ldr_ack", {31'd0, ldr_ack}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        check("rst_ldr_rdata", {16'd0, ldr_rdata}, 32'd0);
        check("rst_owner", {31'd0, owner}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        tick(0, 0, 0, 16'h0);

        // CPU read of 0x3000.
        c = cyc;
        cpu_cs = 1; cpu_we = 0; cpu_addr = 16'h3000;
        expect_pulse(0, c + 3, 16'h1234);
        tick(0, 0, 0, 16'h0);
        tick(1, 0, 0, 16'h3000);
        tick(1, 0, 0, 16'h3000);
        tick(0, 0, 0, 16'h0);
        cpu_cs = 0;
        tick(0, 0, 0, 16'h0);

        // Loader write 0x3001 <- 0xBEEF.
        c = cyc;
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'h3001; ldr_wdata = 16'hBEEF;
        expect_pulse(1, c + 3, 16'h0000);
        tick(0, 0, 0, 16'h0);
        tick(1, 1, 1, 16'h3001);
        tick(1, 1, 1, 16'h3001);
        tick(0, 0, 0, 16'h0);
        ldr_req = 0; ldr_we = 0;
        tick(0, 0, 0, 16'h0);
        check("sram_3001", {16'd0, sram[16'h3001]}, 32'h0000BEEF);
        check("cpu_rdata_after_ldr_write", {16'd0, cpu_rdata}, 32'h00001234);

        // Tie after reset: CPU first; its follow-on request then loses to the loader.
        RESET = 1'b1;
        #1;
        check("rst2_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        c = cyc;
        cpu_cs = 1; cpu_we = 0; cpu_addr = 16'h3000;
        ldr_req = 1; ldr_we = 0; ldr_addr = 16'h3001;
        expect_pulse(0, c + 3, 16'h1234);
        expect_pulse(1, c + 7, 16'hBEEF);
        expect_pulse(0, c + 11, 16'h5678);
        tick(0, 0, 0, 16'h0);
        tick(1, 0, 0, 16'h3000);
        tick(1, 0, 0, 16'h3000);
        tick(0, 0, 0, 16'h0);
        cpu_addr = 16'h3002;
        tick(0, 0, 0, 16'h0);
        tick(1, 0, 1, 16'h3001);
        tick(1, 0, 1, 16'h3001);
        tick(0, 0, 0, 16'h0);
        ldr_req = 0;
        tick(0, 0, 0, 16'h0);
        tick(1, 0, 0, 16'h3002);
        tick(1, 0, 0, 16'h3002);
        tick(0, 0, 0, 16'h0);
        cpu_cs = 0;
        tick(0, 0, 0, 16'h0);

        // CPU cs held across two FSM states: back-to-back reads, one IDLE gap.
        c = cyc;
        cpu_cs = 1; cpu_addr = 16'h3000;
        expect_pulse(0, c + 3, 16'h1234);
        expect_pulse(0, c + 7, 16'h5678);
        tick(0, 0, 0, 16'h0);
        tick(1, 0, 0, 16'h3000);
        tick(1, 0, 0, 16'h3000);
        tick(0, 0, 0, 16'h0);
        cpu_addr = 16'h3002;
        tick(0, 0, 0, 16'h0);
        tick(1, 0, 0, 16'h3002);
        tick(1, 0, 0, 16'h3002);
        tick(0, 0, 0, 16'h0);
        cpu_cs = 0;
        tick(0, 0, 0, 16'h0);

        // Inputs changed mid-access are ignored.
        c = cyc;
        cpu_cs = 1; cpu_we = 0; cpu_addr = 16'h3000;
        expect_pulse(0, c + 3, 16'h1234);
        tick(0, 0, 0, 16'h0);
        cpu_addr = 16'h4000; cpu_we = 1; cpu_wdata = 16'hFFFF;
        tick(1, 0, 0, 16'h3000);
        tick(1, 0, 0, 16'h3000);
        tick(0, 0, 0, 16'h0);
        cpu_cs = 0; cpu_we = 0;
        tick(0, 0, 0, 16'h0);
        check("sram_4000_untouched", {16'd0, sram[16'h4000]}, 32'h0000AAAA);

        // Reset in the second ACCESS cycle, then a fresh write.
        c = cyc;
        cpu_cs = 1; cpu_we = 0; cpu_addr = 16'h3002;
        tick(0, 0, 0, 16'h0);
        tick(1, 0, 0, 16'h3002);
        #2;
        RESET = 1'b1;
        #1;
        check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        check("midrst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        cpu_cs = 0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        c = cyc;
        cpu_cs = 1; cpu_we = 1; cpu_addr = 16'h3003; cpu_wdata = 16'h0F0F;
        expect_pulse(0, c + 3, 16'h0000);
        tick(0, 0, 0, 16'h0);
        tick(1, 1, 0, 16'h3003);
        tick(1, 1, 0, 16'h3003);
        tick(0, 0, 0, 16'h0);
        cpu_cs = 0; cpu_we = 0;
        tick(0, 0, 0, 16'h0);
        tick(0, 0, 0, 16'h0);
        check("sram_3003", {16'd0, sram[16'h3003]}, 32'h00000F0F);
        check("pending_expectations", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
